// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared widths, padding constants and feeder state encoding
package sha256_pkg;

  localparam int BLOCK_W      = 512;
  localparam int DIGEST_W     = 256;
  localparam int BLOCK_BYTES  = BLOCK_W / 8;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int LEN_OFS      = 56;
  localparam int LEN_BITS     = BLOCK_W - 8 * LEN_OFS;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD,
    ST_LEN,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_e;

endpackage

// File: rtl/sha256_block_buf.sv
// rtl/sha256_block_buf.sv - 64-byte block buffer with indexed byte write, pad fill and length insert
module sha256_block_buf
  import sha256_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                wr_en_i,
  input  logic [5:0]          wr_idx_i,
  input  logic [7:0]          wr_data_i,
  input  logic                pad_en_i,
  input  logic                len_en_i,
  input  logic [LEN_BITS-1:0] len_i,
  output logic [BLOCK_W-1:0]  block_o
);

  logic [BLOCK_W-1:0] block_q;

  // pad_en zeroes every byte above wr_idx; a following length insert overwrites 56..63
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q <= '0;
    end else if (clr_i) begin
      block_q <= '0;
    end else begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (wr_en_i && (wr_idx_i == 6'(i))) begin
          block_q[BLOCK_W-1-8*i -: 8] <= wr_data_i;
        end else if (pad_en_i && (6'(i) > wr_idx_i)) begin
          block_q[BLOCK_W-1-8*i -: 8] <= 8'h00;
        end
      end
      if (len_en_i) begin
        block_q[LEN_BITS-1:0] <= len_i;
      end
    end
  end

  assign block_o = block_q;

endmodule

// File: rtl/sha256_msg_feeder.sv
// rtl/sha256_msg_feeder.sv - byte-stream to SHA-256 block issuer with padding and hash chaining
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  input  logic                s_last,
  input  logic                s_nodata,
  output logic                s_ready,
  output logic [BLOCK_W-1:0]  core_block,
  output logic                core_start,
  output logic                core_use_init,
  output logic [DIGEST_W-1:0] core_hash_init,
  input  logic                core_ready,
  input  logic [DIGEST_W-1:0] core_hash,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid
);

  state_e              state_q;
  logic [6:0]          idx_q;
  logic [LEN_W-1:0]    bitlen_q;
  logic                first_q;
  logic                pend_pad_q;
  logic                pend_len_q;
  logic                last_blk_q;
  logic [DIGEST_W-1:0] chain_q;
  logic                s_ready_q;
  logic                core_start_q;
  logic                use_init_q;
  logic [DIGEST_W-1:0] hash_init_q;
  logic [DIGEST_W-1:0] digest_q;
  logic                digest_valid_q;

  logic                accept;
  logic                idx_full;
  logic                buf_wr;
  logic                buf_pad;
  logic                buf_len;
  logic                buf_clr;
  logic [7:0]          buf_data;
  logic [LEN_BITS-1:0] len64;

  always_comb begin
    accept   = (state_q == ST_FILL) && s_valid && s_ready_q;
    idx_full = idx_q[6];
    buf_pad  = (state_q == ST_PAD) && !idx_full;
    buf_wr   = (accept && !s_nodata) || buf_pad;
    buf_data = (state_q == ST_PAD) ? PAD_BYTE : s_data;
    buf_len  = (state_q == ST_LEN);
    buf_clr  = (state_q == ST_WAIT) && core_ready;
    len64    = '0;
    len64[LEN_W-1:0] = bitlen_q;
  end

  sha256_block_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (buf_clr),
    .wr_en_i   (buf_wr),
    .wr_idx_i  (idx_q[5:0]),
    .wr_data_i (buf_data),
    .pad_en_i  (buf_pad),
    .len_en_i  (buf_len),
    .len_i     (len64),
    .block_o   (core_block)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FILL;
      idx_q          <= '0;
      bitlen_q       <= '0;
      first_q        <= 1'b1;
      pend_pad_q     <= 1'b0;
      pend_len_q     <= 1'b0;
      last_blk_q     <= 1'b0;
      chain_q        <= '0;
      s_ready_q      <= 1'b0;
      core_start_q   <= 1'b0;
      use_init_q     <= 1'b0;
      hash_init_q    <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      core_start_q   <= 1'b0;
      digest_valid_q <= 1'b0;
      // Core-facing chain inputs only track while building a block, so they hold from ISSUE through WAIT
      if (state_q inside {ST_FILL, ST_PAD, ST_LEN}) begin
        use_init_q  <= !first_q;
        hash_init_q <= chain_q;
      end
      case (state_q)
        ST_FILL: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            if (!s_nodata) begin
              idx_q    <= idx_q + 7'd1;
              bitlen_q <= bitlen_q + LEN_W'(8);
            end
            if (s_last) begin
              s_ready_q <= 1'b0;
              state_q   <= ST_PAD;
            end else if (!s_nodata && (idx_q == 7'd63)) begin
              s_ready_q    <= 1'b0;
              core_start_q <= 1'b1;
              state_q      <= ST_ISSUE;
            end
          end
        end
        ST_PAD: begin
          if (idx_full) begin
            pend_pad_q   <= 1'b1;
            core_start_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end else if (idx_q <= 7'(LEN_OFS - 1)) begin
            state_q <= ST_LEN;
          end else begin
            pend_len_q   <= 1'b1;
            core_start_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_LEN: begin
          last_blk_q   <= 1'b1;
          core_start_q <= 1'b1;
          state_q      <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_ready) begin
            chain_q <= core_hash;
            first_q <= 1'b0;
            idx_q   <= '0;
            if (last_blk_q) begin
              last_blk_q <= 1'b0;
              state_q    <= ST_OUT;
            end else if (pend_pad_q) begin
              pend_pad_q <= 1'b0;
              state_q    <= ST_PAD;
            end else if (pend_len_q) begin
              pend_len_q <= 1'b0;
              state_q    <= ST_LEN;
            end else begin
              s_ready_q <= 1'b1;
              state_q   <= ST_FILL;
            end
          end
        end
        ST_OUT: begin
          digest_q       <= core_hash;
          digest_valid_q <= 1'b1;
          bitlen_q       <= '0;
          first_q        <= 1'b1;
          s_ready_q      <= 1'b1;
          state_q        <= ST_FILL;
        end
        default: begin
          state_q <= ST_FILL;
        end
      endcase
    end
  end

  assign s_ready        = s_ready_q;
  assign core_start     = core_start_q;
  assign core_use_init  = use_init_q;
  assign core_hash_init = hash_init_q;
  assign digest         = digest_q;
  assign digest_valid   = digest_valid_q;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// tb/tb_sha256_msg_feeder.sv - scoreboard bench for sha256_msg_feeder with a behavioural SHA-256 core
module tb_sha256_msg_feeder;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [255:0] dig;
    int           nblk;
    logic [63:0]  bits;
  } exp_t;

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_448   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   s_data;
  logic         s_valid, s_last, s_nodata;
  logic         s_ready;
  logic [511:0] core_block;
  logic         core_start, core_use_init;
  logic [255:0] core_hash_init;
  logic         core_ready;
  logic [255:0] core_hash;
  logic [255:0] digest;
  logic         digest_valid;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   blk_cnt = 0;
  int   starts_seen = 0;
  logic prev_dv = 1'b0;

  always #5 clk = ~clk;

  sha256_msg_feeder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_nodata       (s_nodata),
    .s_ready        (s_ready),
    .core_block     (core_block),
    .core_start     (core_start),
    .core_use_init  (core_use_init),
    .core_hash_init (core_hash_init),
    .core_ready     (core_ready),
    .core_hash      (core_hash),
    .digest         (digest),
    .digest_valid   (digest_valid)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + h[255:224], b + h[223:192], c + h[191:160], d + h[159:128],
            e + h[127:96],  f + h[95:64],   g + h[63:32],   hh + h[31:0]};
  endfunction

  function automatic logic [255:0] sha_ref(input bq_t m);
    bq_t          p;
    logic [63:0]  bl;
    logic [511:0] blk;
    logic [255:0] h;
    p  = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    h = IV;
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi+j];
      h = sha_compress(h, blk);
    end
    return h;
  endfunction

  function automatic bq_t str_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rep_a(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'h61);
    return q;
  endfunction

  // Behavioural compression core: ready drops the cycle after start, returns after a random latency
  logic [255:0] core_pend;
  int           core_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ready <= 1'b1;
      core_hash  <= '0;
      core_cnt   <= 0;
    end else if (core_start) begin
      core_ready <= 1'b0;
      core_pend  <= sha_compress(core_use_init ? core_hash_init : IV, core_block);
      core_cnt   <= $urandom_range(3, 10);
    end else if (!core_ready) begin
      if (core_cnt == 0) begin
        core_ready <= 1'b1;
        core_hash  <= core_pend;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      blk_cnt = 0;
      prev_dv = 1'b0;
    end else begin
      if (core_start) begin
        check_eq("s_ready_in_issue", s_ready, 1'b0);
        if (sb.size() > 0) begin
          check_eq("use_init", core_use_init, blk_cnt != 0);
          if (blk_cnt + 1 == sb[0].nblk) check_eq("len_field", core_block[63:0], sb[0].bits);
        end
        blk_cnt++;
        starts_seen++;
      end
      if (!core_ready) check_eq("s_ready_in_wait", s_ready, 1'b0);
      if (digest_valid) begin
        check_eq("dv_one_cycle", prev_dv, 1'b0);
        if (sb.size() == 0) begin
          check_eq("unexpected_digest", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check_eq("digest", digest, e.dig);
          check_eq("block_count", blk_cnt, e.nblk);
        end
        blk_cnt = 0;
      end
      prev_dv = digest_valid;
    end
  end

  task automatic expect_msg(input bq_t m, input logic [255:0] dig);
    exp_t e;
    e.dig  = dig;
    e.nblk = (m.size() + 9 + 63) / 64;
    e.bits = 64'(m.size()) * 64'd8;
    sb.push_back(e);
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic last, input logic nodata);
    int budget = 2000;
    s_data   = d;
    s_last   = last;
    s_nodata = nodata;
    s_valid  = 1'b1;
    while (!s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check_eq("s_ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_nodata = 1'b0;
  endtask

  task automatic send_msg(input bq_t m, input int gap_pct, input bit noise);
    if (m.size() == 0) begin
      drive_beat(8'h00, 1'b1, 1'b1);
    end else begin
      for (int i = 0; i < m.size(); i++) begin
        if ($urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 3)) @(negedge clk);
        if (noise && i == m.size() - 1) drive_beat(8'hee, 1'b0, 1'b1);
        drive_beat(m[i], i == m.size() - 1, 1'b0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_s_ready"}, s_ready, 1'b0);
    check_eq({tag, "_core_start"}, core_start, 1'b0);
    check_eq({tag, "_use_init"}, core_use_init, 1'b0);
    check_eq({tag, "_block"}, core_block[255:0] | core_block[511:256], 256'd0);
    check_eq({tag, "_hash_init"}, core_hash_init, 256'd0);
    check_eq({tag, "_digest"}, digest, 256'd0);
    check_eq({tag, "_dv"}, digest_valid, 1'b0);
  endtask

  task automatic drain(input string tag);
    int budget = 20000;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq(tag, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t m;
    int  s0;
    int  budget;
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_nodata = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("s_ready_after_rst", s_ready, 1'b1);

    m = {};                          expect_msg(m, D_EMPTY); send_msg(m, 0, 1'b0);
    m = str_q("abc");                expect_msg(m, D_ABC);   send_msg(m, 0, 1'b0);
    m = str_q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    expect_msg(m, D_448); send_msg(m, 0, 1'b0);
    m = rep_a(55);                   expect_msg(m, sha_ref(m)); send_msg(m, 0, 1'b0);
    m = rep_a(64);                   expect_msg(m, sha_ref(m)); send_msg(m, 0, 1'b0);
    m = str_q("abc");                expect_msg(m, D_ABC);   send_msg(m, 20, 1'b1);

    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(0, 140);
      m = {};
      for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(0, 255)));
      expect_msg(m, sha_ref(m));
      send_msg(m, 30, 1'b0);
    end
    drain("drain_main");

    // Abort a two-block message while its second block is with the core
    s0 = starts_seen;
    m  = str_q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send_msg(m, 0, 1'b0);
    budget = 500;
    while (starts_seen < s0 + 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("abort_reach_wait", starts_seen >= s0 + 2, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("s_ready_after_midrst", s_ready, 1'b1);
    m = str_q("abc"); expect_msg(m, D_ABC); send_msg(m, 0, 1'b0);
    drain("drain_post_rst");
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
